// File: rtl/computie_bus_hexdumper.sv
// computie_bus_hexdumper: streams bus records as ASCII hex lines ("Taaaaaaaa:dddddddd") over a byte handshake.
module computie_bus_hexdumper #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MODWIDTH = 2,
  parameter int CRLF = 0,
  parameter int CNTWIDTH = 16
) (
  input  logic                                   comm_clock,
  input  logic                                   comm_reset,
  input  logic                                   dump_start,
  input  logic                                   dump_abort,
  input  logic [CNTWIDTH-1:0]                    dump_limit,
  output logic                                   dump_busy,
  output logic                                   dump_end,
  output logic [CNTWIDTH-1:0]                    record_count,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [MODWIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [7:0]                             out_data
);
  localparam int RW = MODWIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [4:0] EL = (CRLF != 0) ? 5'd1 : 5'd0;
  localparam logic [4:0] AL = 5'(ADDR_WIDTH / 4 - 1);
  localparam logic [4:0] DL = 5'(DATA_WIDTH / 4 - 1);
  typedef enum logic [3:0] {IDLE, HEADER, FETCH, TAG, ADDR, SEP, DATA, EOL, FOOTER} state_t;
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [RW-1:0] rec, rec_n;
  logic [CNTWIDTH-1:0] cnt_n;
  logic [7:0] data_n;
  logic flag, flag_n, busy_n, valid_n, xfer, abort_eff, last, adv;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  // Byte presented for a given state/digit index, taken from the given record.
  function automatic logic [7:0] byte_of(input state_t s, input logic [4:0] i, input logic [RW-1:0] r);
    logic [1:0] m;
    logic [3:0] an;
    logic [3:0] dn;
    m = 2'(r[RW-1 -: MODWIDTH]);
    an = 4'(r[DATA_WIDTH +: ADDR_WIDTH] >> (4 * (AL - i)));
    dn = 4'(r[DATA_WIDTH-1:0] >> (4 * (DL - i)));
    return (s == TAG) ? ((m == 2'd0) ? "W" : (m == 2'd1) ? "R" : (m == 2'd2) ? "F" : "I") :
           (s == ADDR) ? hex(an) :
           (s == DATA) ? hex(dn) :
           (s == SEP) ? ":" :
           (CRLF != 0 && i == 5'd0) ? 8'h0D : 8'h0A;
  endfunction

  always_comb begin
    xfer = out_valid & out_ready;
    abort_eff = flag | (dump_abort & (state != IDLE) & (state != FOOTER));
    last = idx == ((state == ADDR) ? AL : (state == DATA) ? DL : (state inside {HEADER, EOL, FOOTER}) ? EL : 5'd0);
    in_ready = (state == FETCH) && !abort_eff && !(dump_limit != '0 && record_count == dump_limit) && in_valid;
    dump_end = (state == FOOTER) && xfer && last;
    state_n = state;
    idx_n = idx;
    rec_n = rec;
    cnt_n = record_count;
    flag_n = flag | (dump_abort & ((state == IDLE) ? dump_start : (state != FOOTER)));
    busy_n = dump_busy;
    adv = 1'b0;
    case (state)
      IDLE: if (dump_start) begin
        state_n = HEADER;
        idx_n = 5'd0;
        cnt_n = '0;
        busy_n = 1'b1;
        adv = 1'b1;
      end
      FETCH: begin
        adv = 1'b1;
        idx_n = 5'd0;
        state_n = in_ready ? TAG : FOOTER;
        rec_n = in_ready ? in_data : rec;
        cnt_n = in_ready ? record_count + 1'b1 : record_count;
      end
      default: if (xfer) begin
        adv = 1'b1;
        idx_n = last ? 5'd0 : idx + 5'd1;
        if (abort_eff && state != FOOTER) begin
          state_n = FOOTER;
          idx_n = 5'd0;
        end else if (last)
          state_n = (state == HEADER || state == EOL) ? FETCH : (state == TAG) ? ADDR : (state == ADDR) ? SEP :
                    (state == SEP) ? DATA : (state == DATA) ? EOL : IDLE;
        if (dump_end) begin
          busy_n = 1'b0;
          flag_n = 1'b0;
        end
      end
    endcase
    valid_n = adv ? !(state_n inside {IDLE, FETCH}) : out_valid;
    data_n = (adv && valid_n) ? byte_of(state_n, idx_n, rec_n) : out_data;
  end

  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      state <= IDLE;
      idx <= 5'd0;
      rec <= '0;
      record_count <= '0;
      flag <= 1'b0;
      dump_busy <= 1'b0;
      out_valid <= 1'b0;
      out_data <= 8'h00;
    end else begin
      state <= state_n;
      idx <= idx_n;
      rec <= rec_n;
      record_count <= cnt_n;
      flag <= flag_n;
      dump_busy <= busy_n;
      out_valid <= valid_n;
      out_data <= data_n;
    end
  end
endmodule

// File: tb/tb_computie_bus_hexdumper.sv
// tb_computie_bus_hexdumper: random dumps checked each cycle against a queue-based byte-stream model.
module tb_computie_bus_hexdumper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic comm_reset = 1'b1, dump_start = 1'b0, dump_abort = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] dump_limit = '0;
  logic [65:0] in_data = '0;
  logic dump_busy, dump_end, in_ready, out_valid;
  logic [15:0] record_count;
  logic [7:0] out_data;

  logic s2_start = 1'b0, s2_valid = 1'b0;
  logic [41:0] s2_data = {2'b10, 24'hABCDEF, 16'h0009};
  logic s2_busy, s2_end, s2_ready, s2_ov;
  logic [15:0] s2_cnt;
  logic [7:0] s2_od;

  computie_bus_hexdumper dut (
    .comm_clock(clk), .comm_reset(comm_reset), .dump_start(dump_start), .dump_abort(dump_abort),
    .dump_limit(dump_limit), .dump_busy(dump_busy), .dump_end(dump_end), .record_count(record_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  computie_bus_hexdumper #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .CRLF(1)) dut2 (
    .comm_clock(clk), .comm_reset(comm_reset), .dump_start(s2_start), .dump_abort(1'b0),
    .dump_limit(16'd0), .dump_busy(s2_busy), .dump_end(s2_end), .record_count(s2_cnt),
    .in_valid(s2_valid), .in_ready(s2_ready), .in_data(s2_data),
    .out_valid(s2_ov), .out_ready(1'b1), .out_data(s2_od));

  int nvec = 0, nerr = 0, end_cnt = 0, pop_cnt = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] q[$];
  logic [65:0] src_q[$];
  string log_s = "";
  bit busy_m = 0, foot_m = 0, pv = 0, pr = 0;
  logic [15:0] cnt_m = '0;
  logic [7:0] pd = '0;

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = {r, (s[i] == 8'h0A) ? "~" : (s[i] == 8'h0D) ? "^" : $sformatf("%c", s[i])};
    return r;
  endfunction

  function automatic string hx(logic [63:0] v, int n);
    string h = "0123456789ABCDEF";
    string s = "";
    for (int i = n - 1; i >= 0; i--) s = {s, $sformatf("%c", h[int'(v[4*i +: 4])])};
    return s;
  endfunction

  function automatic string line_of(logic [65:0] r);
    string tg = "WRFI";
    return {$sformatf("%c", tg[int'(r[65:64])]), hx(64'(r[63:32]), 8), ":", hx(64'(r[31:0]), 8), "\n"};
  endfunction

  task automatic push_s(string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chks(string nm, string act, string exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", nm, vis(act), vis(exp));
    end
  endtask

  // Behavioural model: expected byte queue built from whole lines, trimmed on abort.
  always @(negedge clk) begin
    bit fetch, ab, lim, exp_rdy, xfer, b0;
    if (comm_reset) begin
      q.delete();
      busy_m = 0;
      foot_m = 0;
      cnt_m = '0;
      pv = 0;
    end else begin
      b0 = busy_m;
      fetch = busy_m && !foot_m && q.size() == 0;
      ab = dump_abort && busy_m && !foot_m;
      lim = dump_limit != 0 && cnt_m == dump_limit;
      exp_rdy = fetch && !ab && !lim && src_q.size() != 0;
      xfer = out_valid && out_ready;
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("dump_busy", 64'(dump_busy), 64'(busy_m));
      chk("record_count", 64'(record_count), 64'(cnt_m));
      chk("dump_end", 64'(dump_end), 64'(foot_m && xfer && q.size() == 1));
      if (pv && !pr) chk("hold", 64'({out_valid, out_data}), 64'({1'b1, pd}));
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      if (dump_end) end_cnt++;
      if (ab) begin
        if (q.size() > 0) q = q[0:0];
        push_s("\n");
        foot_m = 1;
      end
      if (xfer && q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0]));
        log_s = {log_s, $sformatf("%c", out_data)};
        void'(q.pop_front());
        if (foot_m && q.size() == 0) begin
          busy_m = 0;
          foot_m = 0;
        end
      end
      if (fetch && !ab) begin
        if (exp_rdy) begin
          push_s(line_of(src_q[0]));
          cnt_m++;
        end else begin
          push_s("\n");
          foot_m = 1;
        end
      end
      if (in_ready && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pop_cnt++;
      end
      if (dump_start && !b0) begin
        busy_m = 1;
        cnt_m = '0;
        log_s = "";
        push_s("\n");
        if (dump_abort) foot_m = 1;
        if (dump_abort) push_s("\n");
      end
    end
  end

  task automatic sync_src();
    in_valid = src_q.size() != 0;
    in_data = in_valid ? src_q[0] : '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    sync_src();
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_dump(int lim, bit rnd, int abort_at, bit sab);
    int e0;
    bit aborted = 0;
    dump_limit = 16'(lim);
    rnd_ready = rnd;
    cyc();
    dump_start = 1;
    dump_abort = sab;
    e0 = end_cnt;
    cyc();
    dump_start = 0;
    dump_abort = 0;
    for (int k = 0; k < 3000 && end_cnt == e0; k++) begin
      if (abort_at >= 0 && !aborted && log_s.len() == abort_at) begin
        dump_abort = 1;
        aborted = 1;
      end
      cyc();
      dump_abort = 0;
    end
    chk("dump_end pulses", 64'(end_cnt - e0), 64'd1);
    rnd_ready = 0;
    cyc();
    cyc();
  endtask

  initial begin
    string ref_s, log2;
    int p0, e0;
    bit pop2, done;
    repeat (3) cyc();
    comm_reset = 0;
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset dump_busy", 64'(dump_busy), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset record_count", 64'(record_count), 64'd0);

    src_q.push_back({2'b01, 32'h00001234, 32'hDEADBEEF});
    sync_src();
    run_dump(0, 0, -1, 0);
    chks("basic dump", log_s, "\nR00001234:DEADBEEF\n\n");
    chk("basic count", 64'(record_count), 64'd1);

    for (int i = 0; i < 5; i++) src_q.push_back({2'b00, 32'h1000 + 32'(i), 32'($urandom)});
    sync_src();
    p0 = pop_cnt;
    run_dump(2, 0, -1, 0);
    chk("limit pops", 64'(pop_cnt - p0), 64'd2);
    chk("limit left", 64'(src_q.size()), 64'd3);
    chk("limit count", 64'(record_count), 64'd2);
    chk("limit length", 64'(log_s.len()), 64'd40);
    src_q.delete();
    sync_src();

    src_q.push_back({2'b01, 32'h12345678, 32'h0});
    src_q.push_back({2'b11, 32'h9, 32'h9});
    sync_src();
    p0 = pop_cnt;
    run_dump(0, 0, 4, 0);
    chks("abort dump", log_s, "\nR123\n");
    chk("abort pops", 64'(pop_cnt - p0), 64'd1);
    src_q.delete();
    sync_src();

    run_dump(0, 0, -1, 1);
    chks("start+abort", log_s, "\n\n");
    chk("start+abort count", 64'(record_count), 64'd0);

    for (int i = 0; i < 3; i++) src_q.push_back({2'(i), 32'($urandom), 32'($urandom)});
    begin
      logic [65:0] keep[$];
      keep = src_q;
      sync_src();
      run_dump(0, 0, -1, 0);
      ref_s = log_s;
      src_q = keep;
      sync_src();
      run_dump(0, 1, -1, 0);
      chks("stall stream", log_s, ref_s);
    end

    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(0, 4);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back({2'($urandom), 32'($urandom), 32'($urandom)});
      sync_src();
      run_dump($urandom_range(0, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, $urandom_range(0, 9) == 0);
    end
    src_q.delete();

    src_q.push_back({2'b10, 32'hCAFEF00D, 32'h01234567});
    src_q.push_back({2'b10, 32'hCAFEF00D, 32'h01234567});
    sync_src();
    dump_limit = 0;
    cyc();
    dump_start = 1;
    cyc();
    dump_start = 0;
    for (int k = 0; k < 200 && log_s.len() < 14; k++) cyc();
    e0 = end_cnt;
    comm_reset = 1;
    cyc();
    comm_reset = 0;
    @(negedge clk);
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset out_data", 64'(out_data), 64'd0);
    chk("mid reset busy", 64'(dump_busy), 64'd0);
    chk("mid reset in_ready", 64'(in_ready), 64'd0);
    chk("mid reset dump_end", 64'(dump_end), 64'd0);
    chk("mid reset count", 64'(record_count), 64'd0);
    repeat (5) cyc();
    chk("no end after reset", 64'(end_cnt - e0), 64'd0);
    src_q.delete();
    src_q.push_back({2'b11, 32'h0000ABCD, 32'hF0000001});
    sync_src();
    run_dump(0, 0, -1, 0);
    chks("clean after reset", log_s, "\nI0000ABCD:F0000001\n\n");

    log2 = "";
    done = 0;
    s2_valid = 1;
    s2_start = 1;
    cyc();
    s2_start = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      pop2 = s2_ready;
      if (s2_ov) log2 = {log2, $sformatf("%c", s2_od)};
      if (s2_end) done = 1;
      @(posedge clk);
      #1;
      if (pop2) s2_valid = 0;
    end
    chks("crlf dump", log2, "\r\nFABCDEF:0009\r\n\r\n");
    chk("crlf count", 64'(s2_cnt), 64'd1);
    chk("crlf busy", 64'(s2_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
